// File: rtl/axi_ram_responder.sv
// Single-port word RAM behind a minimal AXI3-style slave: INCR bursts only,
// one outstanding transaction per channel, independent read and write FSMs.
module axi_ram_responder #(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        dbg_r_state,
  output logic [1:0]  dbg_w_state
);

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  logic [31:0]       mem [2**MEM_AW];
  logic [0:0]        r_state;
  logic [MEM_AW-1:0] r_idx;
  logic [3:0]        r_cnt;
  logic [3:0]        r_id;
  logic [1:0]        w_state;
  logic [MEM_AW-1:0] w_idx;
  logic [3:0]        w_len;
  logic [3:0]        w_id;
  logic              r_hs;
  logic              w_hs;
  logic              unused_bits;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a source holds its payload stable until that edge. Reset masks every
  // ready/valid this module drives so nothing transfers while rst=1.
  assign arready = rst || (r_state == R_IDLE);
  assign rvalid  = !rst && (r_state == R_BURST);
  assign rlast   = rvalid && (r_cnt == 4'd0);
  assign rdata   = rvalid ? mem[r_idx] : 32'd0;
  assign rid     = rst ? 4'd0 : r_id;
  assign rresp   = 2'b00;
  assign awready = rst || (w_state == W_IDLE);
  assign wready  = !rst && (w_state == W_DATA);
  assign bvalid  = !rst && (w_state == W_RESP);
  assign bid     = rst ? 4'd0 : w_id;
  assign bresp   = 2'b00;
  assign r_hs    = rvalid && rready;
  assign w_hs    = wvalid && wready;

  assign dbg_r_state = r_state;
  assign dbg_w_state = w_state;

  // awlen is recorded only; wlast ends the burst. Byte-offset and aliased upper
  // address bits are intentionally dropped.
  assign unused_bits = ^{araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0], w_len};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_id    <= arid;
          r_idx   <= araddr[MEM_AW+1:2];
          r_cnt   <= arlen;
          r_state <= R_BURST;
        end
        default: if (r_hs) begin
          r_idx <= r_idx + MEM_AW'(1);
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) r_state <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_len   <= '0;
      w_id    <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_id    <= awid;
          w_idx   <= awaddr[MEM_AW+1:2];
          w_len   <= awlen;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_idx <= w_idx + MEM_AW'(1);
          if (wlast) w_state <= W_RESP;
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // The combinational read above sees the pre-edge contents, so a same-cycle
  // read and write of one word returns the old data.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized bench for axi_ram_responder with a transaction-level memory model
// and a per-cycle output checker, plus directed literal cases.
module tb_axi_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arlen, awlen;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        dbg_r_state;
  logic [1:0]  dbg_w_state;

  axi_ram_responder #(.MEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void timeout(input string name);
    n_chk++;
    $display("FAIL timeout_%s: no handshake within bound at %0t", name, $time);
  endfunction

  // ---------------- reference model: 4096-word memory + channel status
  logic [31:0] m_mem [4096];
  bit          m_rbusy = 0;
  logic [11:0] m_ridx;
  int          m_rrem;
  logic [3:0]  m_rid;
  int          m_wphase = 0;   // 0 address, 1 data, 2 response
  logic [11:0] m_widx;
  logic [3:0]  m_wid;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_arready", arready, 1);
      chk("rst_awready", awready, 1);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rid", rid, 0);
      chk("rst_bid", bid, 0);
      chk("rst_rdata", rdata, 0);
      m_rbusy = 0;
      m_wphase = 0;
    end else begin
      chk("arready", arready, !m_rbusy);
      chk("rvalid", rvalid, m_rbusy);
      chk("awready", awready, m_wphase == 0);
      chk("wready", wready, m_wphase == 1);
      chk("bvalid", bvalid, m_wphase == 2);
      if (m_rbusy) begin
        chk("rdata", rdata, m_mem[m_ridx]);
        chk("rlast", rlast, m_rrem == 1);
        chk("rid", rid, m_rid);
        chk("rresp", rresp, 0);
      end
      if (m_wphase == 2) begin
        chk("bid", bid, m_wid);
        chk("bresp", bresp, 0);
      end
      // Transfers that the coming rising edge will perform; reads use the old data.
      if (m_rbusy) begin
        if (rready) begin
          m_ridx = m_ridx + 12'd1;
          m_rrem--;
          if (m_rrem == 0) m_rbusy = 0;
        end
      end else if (arvalid) begin
        m_rbusy = 1;
        m_rid = arid;
        m_ridx = araddr[13:2];
        m_rrem = int'(arlen) + 1;
      end
      if (m_wphase == 0 && awvalid) begin
        m_wphase = 1;
        m_wid = awid;
        m_widx = awaddr[13:2];
      end else if (m_wphase == 1 && wvalid) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m_mem[m_widx][8*b +: 8] = wdata[8*b +: 8];
        m_widx = m_widx + 12'd1;
        if (wlast) m_wphase = 2;
      end else if (m_wphase == 2 && bready) begin
        m_wphase = 0;
      end
    end
  end

  // ---------------- drivers
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] rq_got[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id,
                           input logic [3:0] len, input bit throttle);
    int n, t;
    n = wq_data.size();
    awid = id; awaddr = addr; awlen = len; awvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    if (!awready) begin timeout("aw"); step(); awvalid = 0; return; end
    step(); awvalid = 0;
    for (int i = 0; i < n; i++) begin
      if (throttle) while ($urandom_range(0, 2) == 0) step();
      wvalid = 1; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == n - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 100);
      if (!wready) begin timeout("w"); step(); wvalid = 0; wlast = 0; return; end
      step(); wvalid = 0; wlast = 0;
    end
    t = 0;
    forever begin
      bready = (throttle) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); t++;
      if (bvalid && bready) break;
      if (t >= 100) begin timeout("b"); break; end
      step();
    end
    step(); bready = 0;
  endtask

  // mode 0: rready always 1; 1: toggles 1,0,1,0...; 2: random
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                          input logic [3:0] len, input int mode);
    int t, k;
    arid = id; araddr = addr; arlen = len; arvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    if (!arready) begin timeout("ar"); step(); arvalid = 0; return; end
    step(); arvalid = 0;
    rq_got.delete();
    k = 0; t = 0;
    while (rq_got.size() < int'(len) + 1 && t < 200) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ~k[0] : 1'($urandom_range(0, 1));
      k++;
      @(negedge clk); t++;
      if (rvalid && rready) rq_got.push_back(rdata);
      step();
    end
    rready = 0;
    if (rq_got.size() < int'(len) + 1) timeout("r");
  endtask

  task automatic push_w(input logic [31:0] d, input logic [3:0] s);
    wq_data.push_back(d); wq_strb.push_back(s);
  endtask

  task automatic check_read(input string name, input int idx, input logic [31:0] exp);
    if (idx < rq_got.size()) chk(name, rq_got[idx], exp);
    else timeout(name);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : 32'(4096 - $urandom_range(1, 8));
    return ($urandom & 32'hFFFF_C000) | (w << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic fill_w(input int n);
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < n; i++) push_w($urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    rst = 1;
    arid = 0; araddr = 0; arlen = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    repeat (3) step();
    rst = 0;
    step();

    // Preload all words in one wlast-terminated burst (awlen is irrelevant).
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 4096; i++) push_w($urandom, 4'hF);
    axi_write(32'h0, 4'h1, 4'hF, 0);

    // Single-beat write then read.
    wq_data.delete(); wq_strb.delete();
    push_w(32'hDEAD_BEEF, 4'hF);
    axi_write(32'h100, 4'h3, 4'h0, 0);
    axi_read(32'h100, 4'h5, 4'h0, 0);
    chk("d041_beats", rq_got.size(), 1);
    check_read("d041_data", 0, 32'hDEAD_BEEF);

    // Partial strobes merge into the old word.
    wq_data.delete(); wq_strb.delete();
    push_w(32'hAABB_CCDD, 4'hF);
    axi_write(32'h400, 4'h2, 4'h0, 0);
    wq_data.delete(); wq_strb.delete();
    push_w(32'h1122_3344, 4'h3);
    axi_write(32'h400, 4'h2, 4'h0, 0);
    axi_read(32'h400, 4'h7, 4'h0, 0);
    check_read("d043_merge", 0, 32'hAABB_3344);

    // Four known words at 0x80..0x83, read back with rready toggling.
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 4; i++) push_w(32'h1000_0000 + 32'(i), 4'hF);
    axi_write(32'h200, 4'h4, 4'h3, 1);
    axi_read(32'h200, 4'h9, 4'h3, 1);
    chk("d042_beats", rq_got.size(), 4);
    for (int i = 0; i < 4; i++) check_read("d042_data", i, 32'h1000_0000 + 32'(i));

    // Wrap from last word to word 0; upper address bits alias.
    wq_data.delete(); wq_strb.delete();
    push_w(32'hCAFE_F00D, 4'hF);
    push_w(32'h0BAD_C0DE, 4'hF);
    axi_write(32'h3FFC, 4'h6, 4'h0, 0);  // awlen 0 but wlast on beat 2
    axi_read(32'h0000_3FFC, 4'hA, 4'h1, 0);
    check_read("d044_last", 0, 32'hCAFE_F00D);
    check_read("d044_wrap", 1, 32'h0BAD_C0DE);
    axi_read(32'h1000_0100, 4'hB, 4'h0, 0);
    check_read("d044_alias", 0, 32'hDEAD_BEEF);

    // Random traffic in a small window plus the top of memory; some overlapped.
    for (int it = 0; it < 80; it++) begin
      int sel;
      logic [31:0] wa, ra;
      sel = $urandom_range(0, 2);
      wa = rand_addr();
      ra = ($urandom_range(0, 1) == 1) ? wa : rand_addr();
      fill_w($urandom_range(1, 6));
      if (sel == 0)
        axi_write(wa, 4'($urandom), 4'($urandom), 1);
      else if (sel == 1)
        axi_read(ra, 4'($urandom), 4'($urandom_range(0, 7)), 2);
      else
        fork
          axi_write(wa, 4'($urandom), 4'($urandom), $urandom_range(0, 1) == 1);
          axi_read(ra, 4'($urandom), 4'($urandom_range(0, 7)), $urandom_range(0, 2));
        join
    end

    // Reset during the 2nd beat of a 4-beat read and during write data phase.
    arid = 4'hC; araddr = 32'h200; arlen = 4'h3; arvalid = 1;
    awid = 4'hD; awaddr = 32'h300; awlen = 4'h1; awvalid = 1;
    step();
    arvalid = 0; awvalid = 0; rready = 1;
    step();
    rst = 1; rready = 0;
    step();
    rst = 0;
    @(negedge clk);
    chk("d045_rvalid", rvalid, 0);
    chk("d045_wready", wready, 0);
    chk("d045_arready", arready, 1);
    chk("d045_awready", awready, 1);
    step();
    axi_read(32'h200, 4'h1, 4'h3, 0);
    for (int i = 0; i < 4; i++) check_read("d045_keep", i, 32'h1000_0000 + 32'(i));
    axi_read(32'h100, 4'h2, 4'h0, 0);
    check_read("d045_keep100", 0, 32'hDEAD_BEEF);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axi_ram_responder.md
AXI_RAM_RESPONDER -- requirements
Module: axi_ram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning log2 of the number of 32-bit memory words (4096 words = 16 KiB).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port arid, input, 4 bits: read ID.
REQ-005 SHALL have port araddr, input, 32 bits: read byte address.
REQ-006 SHALL have port arlen, input, 4 bits: read beats minus 1.
REQ-007 SHALL have port arvalid, input, 1 bit: read address valid.
REQ-008 SHALL have port arready, output, 1 bit: read address ready.
REQ-009 SHALL have port rid, output, 4 bits: echo of the latched arid.
REQ-010 SHALL have port rdata, output, 32 bits: read data.
REQ-011 SHALL have port rresp, output, 2 bits: read response, constant 2'b00.
REQ-012 SHALL have port rlast, output, 1 bit: final read beat.
REQ-013 SHALL have port rvalid, output, 1 bit: read data valid.
REQ-014 SHALL have port rready, input, 1 bit: read data ready.
REQ-015 SHALL have port awid, input, 4 bits: write ID.
REQ-016 SHALL have port awaddr, input, 32 bits: write byte address.
REQ-017 SHALL have port awlen, input, 4 bits: write beats minus 1.
REQ-018 SHALL have port awvalid, input, 1 bit: write address valid.
REQ-019 SHALL have port awready, output, 1 bit: write address ready.
REQ-020 SHALL have port wdata, input, 32 bits: write data.
REQ-021 SHALL have port wstrb, input, 4 bits: byte enables.
REQ-022 SHALL have port wlast, input, 1 bit: final write beat.
REQ-023 SHALL have port wvalid, input, 1 bit: write data valid.
REQ-024 SHALL have port wready, output, 1 bit: write data ready.
REQ-025 SHALL have port bid, output, 4 bits: echo of the latched awid.
REQ-026 SHALL have port bresp, output, 2 bits: write response, constant 2'b00.
REQ-027 SHALL have port bvalid, output, 1 bit: write response valid.
REQ-028 SHALL have port bready, input, 1 bit: write response ready.

Function
REQ-029 SHALL treat every burst as INCR with 4-byte beats; word index = addr[MEM_AW+1:2]; upper address bits and addr[1:0] ignored (aliasing).
REQ-030 SHALL run independent read and write FSMs; one outstanding transaction per channel.
REQ-031 Read FSM states: R_IDLE (arready=1, rvalid=0) and R_BURST (arready=0, rvalid=1).
REQ-032 On arvalid&arready: latch arid, word index and count=arlen; go to R_BURST next cycle, so the first beat is valid 1 cycle after the AR handshake.
REQ-033 In R_BURST: rdata = mem[index] (combinational); rlast = (count==0); rdata, rlast and rid SHALL hold stable while rready=0.
REQ-034 On rvalid&rready: index+1 modulo 2^MEM_AW, count-1; on the rlast beat, return to R_IDLE (next AR accepted no earlier than the following cycle).
REQ-035 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); awready, wready and bvalid SHALL be 0 in all other states.
REQ-036 On awvalid&awready: latch awid and word index; go to W_DATA.
REQ-037 On wvalid&wready: write each byte lane i where wstrb[i]=1; index+1 modulo 2^MEM_AW; wlast alone terminates the burst and moves the FSM to W_RESP (awlen is only recorded).
REQ-038 In W_RESP: hold bvalid=1 and bid; on bready, return to W_IDLE.
REQ-039 Same-cycle read beat and write beat to the same word SHALL return the old data (read-before-write).

Reset
REQ-040 While rst=1: both FSMs go to IDLE; arready=1, awready=1; rvalid, rlast, wready, bvalid = 0; rid, bid, rdata = 0; this aborts any burst in progress, and memory contents are not cleared.

Verification
REQ-041 AW 0x100 len 0, W 0xDEADBEEF strb 0xF, then AR 0x100 len 0 -> one beat rdata=0xDEADBEEF, rlast=1, rresp=0, bresp=0.
REQ-042 AR 0x200 len 3 with rready toggled 1,0,1,0... -> 4 beats from words 0x80..0x83, data stable during stalls, rlast only on the 4th beat.
REQ-043 Write strb 0x3 with data 0x11223344 over 0xAABBCCDD -> read returns 0xAABB3344.
REQ-044 AR len 1 at the last word -> second beat returns word 0 (wrap); araddr 0x1000_0100 returns the same data as 0x100.
REQ-045 Assert rst during the 2nd beat of a 4-beat read and during W_DATA -> next cycle rvalid=0, wready=0, arready=1, awready=1; previously written data is still readable.
